// File: rtl/mul_cu.sv
// Moore control unit for the 4x4 shift-add multiplier datapath.
// Optional MUL_CU_EARLY_EXIT_EN: leave the iteration loop as soon as B == 0.
module mul_cu #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic b0,
  input  logic z,
  output logic ldA,
  output logic ctrlA,
  output logic ldB,
  output logic ctrlB,
  output logic ldP,
  output logic Psel,
  output logic busy,
  output logic done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            exit_w;
  logic            ldA_q, ctrlA_q, ldB_q, ctrlB_q, ldP_q, Psel_q, busy_q, done_q;

`ifdef MUL_CU_EARLY_EXIT_EN
  assign exit_w = z || (cnt_q == CW'(N));
`else
  logic unused_z;
  assign unused_z = z;
  assign exit_w   = (cnt_q == CW'(N));
`endif

  always_comb begin
    state_d = S_IDLE;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:  state_d = start ? S_LOAD : S_IDLE;
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (exit_w)  state_d = S_DONE;
        else if (b0) state_d = S_ADD;
        else         state_d = S_SHIFT;
      end
      S_ADD:   state_d = S_SHIFT;
      S_SHIFT: begin
        cnt_d   = cnt_q + CW'(1);
        state_d = S_CHECK;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ldA_q   <= 1'b0;
      ctrlA_q <= 1'b0;
      ldB_q   <= 1'b0;
      ctrlB_q <= 1'b0;
      ldP_q   <= 1'b0;
      Psel_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ldA_q   <= (state_d == S_LOAD) || (state_d == S_SHIFT);
      ctrlA_q <= (state_d == S_LOAD);
      ldB_q   <= (state_d == S_LOAD) || (state_d == S_SHIFT);
      ctrlB_q <= (state_d == S_LOAD);
      ldP_q   <= (state_d == S_LOAD) || (state_d == S_ADD);
      Psel_q  <= (state_d == S_ADD);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign ldA   = ldA_q;
  assign ctrlA = ctrlA_q;
  assign ldB   = ldB_q;
  assign ctrlB = ctrlB_q;
  assign ldP   = ldP_q;
  assign Psel  = Psel_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_mul_cu.sv
// Bench for mul_cu: behavioural shift-add datapath plus table, random and corner sequences.
module tb_mul_cu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic b0, z;
  logic ldA, ctrlA, ldB, ctrlB, ldP, Psel, busy, done;
  logic [3:0] dataA = '0, dataB = '0;
  logic [7:0] regA, regP;
  logic [3:0] regB;
  logic [7:0] outs;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mul_cu #(.N(4), .CW(3)) dut (
    .clk(clk), .rst(rst), .start(start), .b0(b0), .z(z),
    .ldA(ldA), .ctrlA(ctrlA), .ldB(ldB), .ctrlB(ctrlB),
    .ldP(ldP), .Psel(Psel), .busy(busy), .done(done)
  );

  // Datapath environment driven by the strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regA <= '0; regB <= '0; regP <= '0;
    end else begin
      if (ldA) regA <= ctrlA ? {4'b0, dataA} : (regA << 1);
      if (ldB) regB <= ctrlB ? dataB : (regB >> 1);
      if (ldP) regP <= Psel ? (regP + regA) : 8'd0;
    end
  end
  assign b0 = regB[0];
  assign z  = (regB == 4'd0);
  assign outs = {ldA, ctrlA, ldB, ctrlB, ldP, Psel, busy, done};

  localparam logic [7:0] SIG_LOAD = 8'b1111_1010;
  localparam logic [7:0] SIG_DONE = 8'b0000_0011;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int popcount4(input logic [3:0] b);
    int c = 0;
    for (int i = 0; i < 4; i++) c += b[i];
    return c;
  endfunction

  // Cycle of done after E0: LOAD, per-iteration CHECK+SHIFT, one ADD per set bit, final CHECK, DONE
  function automatic int model_cycles(input logic [3:0] b);
    int iters = 4;
`ifdef MUL_CU_EARLY_EXIT_EN
    iters = 0;
    for (int i = 0; i < 4; i++) if (b[i]) iters = i + 1;
`endif
    return 3 + 2 * iters + popcount4(b);
  endfunction

  task automatic run_op(input string name, input logic [3:0] a, input logic [3:0] b,
                        input int exp_p, input int exp_cyc, input bit extra);
    int done_cyc = -1, dones = 0, loads = 0, adds = 0, busy_err = 0, strobe_err = 0;
    int p_at_done = -1;
    int first_sig = 0;
    @(negedge clk);
    dataA = a; dataB = b; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= exp_cyc + 2 && k <= 45; k++) begin
      #1;
      if (k == 1) begin start = 1'b0; first_sig = int'(outs); end
      if (extra && k == 3) start = 1'b1;
      if (extra && k == 5) start = 1'b0;
      if (ldA && ctrlA) loads++;
      if (ldP && Psel) adds++;
      if (busy != (k <= exp_cyc)) busy_err++;
      if (done) begin
        dones++; done_cyc = k; p_at_done = int'(regP);
        if (outs != SIG_DONE) strobe_err++;
      end
      @(posedge clk);
    end
    check({name, " load_sig"}, first_sig, int'(SIG_LOAD));
    check({name, " done_cycle"}, done_cyc, exp_cyc);
    check({name, " done_count"}, dones, 1);
    check({name, " load_count"}, loads, 1);
    check({name, " add_count"}, adds, popcount4(b));
    check({name, " busy_errs"}, busy_err, 0);
    check({name, " done_strobes"}, strobe_err, 0);
    check({name, " P"}, p_at_done, exp_p);
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    int         p;
    int         cyc;
    bit         extra;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{a: 4'd3,  b: 4'd5,  p: 15,  cyc: 13, extra: 1'b0};
    vecs[1] = '{a: 4'd15, b: 4'd15, p: 225, cyc: 15, extra: 1'b0};
`ifdef MUL_CU_EARLY_EXIT_EN
    vecs[0].cyc = 11;
    vecs[2] = '{a: 4'd9, b: 4'd0, p: 0, cyc: 3, extra: 1'b0};
    vecs[3] = '{a: 4'd7, b: 4'd1, p: 7, cyc: 6, extra: 1'b1};
`else
    vecs[2] = '{a: 4'd9, b: 4'd0, p: 0, cyc: 11, extra: 1'b0};
    vecs[3] = '{a: 4'd7, b: 4'd1, p: 7, cyc: 12, extra: 1'b1};
`endif

    #1;
    check("reset_outs", int'(outs), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                             vecs[i].p, vecs[i].cyc, vecs[i].extra);

    for (int i = 0; i < 15; i++) begin
      logic [3:0] ra, rb;
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      run_op($sformatf("rnd%0d_%0dx%0d", i, ra, rb), ra, rb, int'(ra) * int'(rb),
             model_cycles(rb), 1'b0);
    end

    // Asynchronous reset while in ADD
    begin
      bit seen_add = 1'b0;
      @(negedge clk);
      dataA = 4'd3; dataB = 4'd5; start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 20 && !seen_add; k++) begin
        #1;
        start = 1'b0;
        if (ldP && Psel) seen_add = 1'b1;
        else @(posedge clk);
      end
      check("rst_add_reached", int'(seen_add), 1);
      #1 rst = 1'b1;
      #1;
      check("rst_async_outs", int'(outs), 0);
      check("rst_async_P", int'(regP), 0);
      @(negedge clk);
      rst = 1'b0;
      run_op("post_rst", 4'd2, 4'd3, 6, model_cycles(4'd3), 1'b0);
    end

    // start held high: back-to-back operations with one idle cycle between
    begin
      int exp_cyc, exp_dones = 0, dones = 0, last_done = -10, gap_err = 0, p_err = 0;
      exp_cyc = model_cycles(4'd1);
      for (int l = 1; l <= 40; l += exp_cyc + 1) exp_dones++;
      @(negedge clk);
      dataA = 4'd1; dataB = 4'd1; start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 80; k++) begin
        #1;
        if (k == 40) start = 1'b0;
        if (done) begin
          dones++; last_done = k;
          if (regP != 8'd1) p_err++;
        end
        if (k == last_done + 1 && outs != 8'd0) gap_err++;
        if (k == last_done + 2 && k <= 40 && outs != SIG_LOAD) gap_err++;
        @(posedge clk);
      end
      check("b2b_done_count", dones, exp_dones);
      check("b2b_gap_errs", gap_err, 0);
      check("b2b_P_errs", p_err, 0);
      #1;
      check("b2b_final_idle", int'(outs), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/mul_cu.md
Name: mul_cu

Overview:
- Control unit for the 4x4 shift-add multiplier datapath (`du`).
- Sits directly upstream of `du` and drives its load/shift/select strobes: ctrlA, ctrlB, ldA, ldB, Psel, ldP.
- Consumes the datapath status bits b0 (LSB of B) and z (B == 0).
- Exposes a start/busy/done handshake to the surrounding system.

Parameters:
- N, 4, multiplier width; number of shift iterations in fixed-latency mode (equals `du` B width).
- CW, 3, iteration counter width; must hold the value N.

Ports:
- clk  input  1  rising-edge clock, shared with `du`.
- rst  input  1  asynchronous active-high reset, shared with `du`.
- start  input  1  request; sampled only in IDLE.
- b0  input  1  `du` B[0].
- z  input  1  `du` B == 0.
- ldA  output  1  `du` A-register enable.
- ctrlA  output  1  `du` A load(1)/shift-left(0) select.
- ldB  output  1  `du` B-register enable.
- ctrlB  output  1  `du` B load(1)/shift-right(0) select.
- ldP  output  1  `du` P-register enable.
- Psel  output  1  `du` P input select: 1 = A+P, 0 = clear.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; P is valid in this cycle.

Behaviour:
- Moore FSM. All outputs decode from the state register only; no combinational path from any input to any output.
- Reset (async, any time including mid-operation): state = IDLE, iteration count = 0, all outputs 0. `du` is cleared by the same rst.
- IDLE: all strobes 0, busy = 0, done = 0. On start = 1, go to LOAD.
- LOAD (1 cycle): ldA = ctrlA = ldB = ctrlB = 1, ldP = 1, Psel = 0 (loads A and B, clears P). Iteration count is cleared to 0. Go to CHECK.
- CHECK (1 cycle): no strobes asserted.
  - If the exit condition holds, go to DONE.
  - Otherwise, if b0 = 1, go to ADD; if b0 = 0, go to SHIFT.
- ADD (1 cycle): ldP = 1, Psel = 1. Go to SHIFT.
- SHIFT (1 cycle): ldA = 1, ctrlA = 0, ldB = 1, ctrlB = 0. Iteration count increments by 1. Go to CHECK.
- DONE (1 cycle): done = 1, no strobes. Go to IDLE.
- Exit condition (default build): iteration count == N.
- Strobes absent in IDLE, CHECK and DONE, so P holds its result until the next LOAD.
- start is ignored while busy = 1. A start held high through DONE begins a new operation from the following IDLE cycle (back-to-back operation, one idle cycle between).
- Latency (default build): start sampled at clock edge E0.
  - done is high in cycle 11 + popcount(B) after E0 (N = 4).
  - busy is high in cycles 1 through 11 + popcount(B).
- Iteration count never exceeds N and does not wrap in legal operation.
- b0 and z are ignored outside CHECK.
- Illegal state encodings go to IDLE on the next clock.

Optional Feature:
- Macro: MUL_CU_EARLY_EXIT_EN.
- Defined: exit condition becomes (z == 1) OR (iteration count == N). Latency is data-dependent.
  - B = 0: done in cycle 3 after E0.
  - In general, done arrives after (index of highest set bit of B) + 1 iterations.
- Undefined: fixed N iterations; z is unused.

Test Plan:
- Reset, then dataA = 3, dataB = 5, start pulse (default build) -> LOAD at cycle 1; ADD in cycles 3 and 8; done = 1 only in cycle 13; P = 15.
- dataA = 15, dataB = 15 (default build) -> four ADD cycles; done in cycle 15; P = 225; no strobe is asserted in the DONE cycle.
- dataB = 0, dataA = 9: default build gives done in cycle 11, P = 0; with MUL_CU_EARLY_EXIT_EN, done in cycle 3, P = 0.
- With MUL_CU_EARLY_EXIT_EN, dataA = 7, dataB = 1 -> done in cycle 6, P = 7. Extra start pulses while busy cause no re-LOAD.
- Assert rst during the ADD state -> all outputs 0 immediately (asynchronously), busy = 0, P = 0. A later start with A = 2, B = 3 -> P = 6.
- start held high for 40 cycles with A = 1, B = 1 -> repeated operations. Each done is followed by exactly one IDLE cycle, then LOAD.
